// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS (x^8 + x^4 + x^3 + x^2 + 1) generator/checker pair.
// prbs8_predict unrolls the recurrence over one word of up to eight bits.
package prbs_pkg;

    localparam int          PRBS8_WIDTH = 8;
    localparam logic [7:0]  PRBS8_TAPS  = 8'h1D;
    // History bits feeding s[m] = s[m-4]^s[m-5]^s[m-6]^s[m-8] when h[0] is the newest bit.
    localparam logic [7:0]  PRBS8_HIST_MASK = 8'hB8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_t;

    typedef struct packed {
        logic [7:0] pred;
        logic [7:0] next_hist;
    } prbs8_pred_t;

    // Bit n-1 of data/pred is earliest in time. self_sync shifts the received
    // bits into the history, otherwise the predicted bits (free-running).
    function automatic prbs8_pred_t prbs8_predict(input logic [7:0] history,
                                                  input logic [7:0] data,
                                                  input int         n,
                                                  input logic       self_sync);
        prbs8_pred_t r;
        logic [7:0]  h;
        logic        p;
        r = '0;
        h = history;
        for (int i = PRBS8_WIDTH - 1; i >= 0; i--) begin
            if (i < n) begin
                p         = ^(h & PRBS8_HIST_MASK);
                r.pred[i] = p;
                h         = {h[6:0], self_sync ? data[i] : p};
            end
        end
        r.next_hist = h;
        return r;
    endfunction

endpackage

// File: rtl/prbs_error_counter.sv
// Saturating bit-error counter: adds the popcount of a mismatch mask, with a
// synchronous clear that takes priority over a same-cycle increment.
module prbs_error_counter #(
    parameter int WIDTH_IN  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH_IN-1:0]  mask,
    input  logic                 count_en,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int POP_W = $clog2(WIDTH_IN + 1);
    localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [POP_W-1:0]   pop;
    logic [CNT_WIDTH:0] sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH_IN; i++) begin
            pop = pop + POP_W'(mask[i]);
        end
        sum = {1'b0, count} + (CNT_WIDTH + 1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= (sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS8 checker: fills and searches on received history,
// then free-runs its own prediction while locked and reports bit errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int BITS_PER_CLOCK = 1,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_COUNT   = 4,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [BITS_PER_CLOCK-1:0] data_in,
    input  logic                      data_valid,
    input  logic                      clear_counts,
    output logic                      locked,
    output logic [BITS_PER_CLOCK-1:0] bit_error,
    output logic                      error_valid,
    output logic [ERR_CNT_WIDTH-1:0]  error_count
);

    localparam int N          = BITS_PER_CLOCK;
    localparam int FILL_WORDS = (PRBS8_WIDTH + N - 1) / N;
    localparam int FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int RUN_W      = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W      = $clog2(UNLOCK_COUNT + 1);

    if (BITS_PER_CLOCK < 1 || BITS_PER_CLOCK > PRBS8_WIDTH) begin : g_bad_bits
        $error("prbs_checker: BITS_PER_CLOCK must be in 1..8");
    end
    if (LOCK_COUNT < 1 || UNLOCK_COUNT < 1 || ERR_CNT_WIDTH < 4) begin : g_bad_counts
        $error("prbs_checker: LOCK_COUNT/UNLOCK_COUNT must be >= 1, ERR_CNT_WIDTH >= 4");
    end

    prbs_state_t      state, state_next;
    logic [7:0]       hist, hist_next;
    logic [FILL_W-1:0] fill_cnt, fill_next;
    logic [RUN_W-1:0] run_cnt, run_next;
    logic [BAD_W-1:0] bad_cnt, bad_next;

    logic [7:0]       data_ext, sel_pred, mismatch8;
    logic [N-1:0]     mismatch;
    prbs8_pred_t      sync_pred, free_pred;
    logic             filling, clean, word_locked;

    // NOTE: every signal gets a default before the decision logic, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        data_ext         = '0;
        data_ext[N-1:0]  = data_in;
        sync_pred        = prbs8_predict(hist, data_ext, N, 1'b1);
        free_pred        = prbs8_predict(hist, data_ext, N, 1'b0);
        sel_pred         = (state == LOCKED) ? free_pred.pred : sync_pred.pred;
        mismatch8        = sel_pred ^ data_ext;
        mismatch         = mismatch8[N-1:0];
        filling          = fill_cnt < FILL_W'(FILL_WORDS);
        // An all-zero history predicts zeros forever, so it never counts as clean.
        clean            = (mismatch8 == '0) && (hist != '0);

        state_next  = state;
        hist_next   = hist;
        fill_next   = fill_cnt;
        run_next    = run_cnt;
        bad_next    = bad_cnt;
        word_locked = 1'b0;

        if (data_valid) begin
            unique case (state)
                SEARCH: begin
                    hist_next = sync_pred.next_hist;
                    if (filling) begin
                        fill_next = fill_cnt + FILL_W'(1);
                    end else if (!clean) begin
                        run_next = '0;
                    end else if (run_cnt == RUN_W'(LOCK_COUNT - 1)) begin
                        state_next = LOCKED;
                        run_next   = '0;
                        bad_next   = '0;
                    end else begin
                        run_next = run_cnt + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    hist_next   = free_pred.next_hist;
                    word_locked = 1'b1;
                    if (mismatch8 == '0) begin
                        bad_next = '0;
                    end else if (bad_cnt == BAD_W'(UNLOCK_COUNT - 1)) begin
                        state_next = SEARCH;
                        fill_next  = '0;
                        run_next   = '0;
                        bad_next   = '0;
                    end else begin
                        bad_next = bad_cnt + BAD_W'(1);
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEARCH;
            hist        <= '0;
            fill_cnt    <= '0;
            run_cnt     <= '0;
            bad_cnt     <= '0;
            bit_error   <= '0;
            error_valid <= 1'b0;
        end else begin
            state       <= state_next;
            hist        <= hist_next;
            fill_cnt    <= fill_next;
            run_cnt     <= run_next;
            bad_cnt     <= bad_next;
            error_valid <= word_locked;
            if (word_locked) begin
                bit_error <= mismatch;
            end
        end
    end

    assign locked = (state == LOCKED);

    prbs_error_counter #(
        .WIDTH_IN  (N),
        .CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_error_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .mask     (mismatch),
        .count_en (word_locked),
        .clear    (clear_counts),
        .count    (error_count)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: three instances (N=1, N=4, N=8 with a 4-bit counter)
// driven by recurrence-built streams and compared every cycle to a bit-level model.
module tb_prbs_checker;

    localparam int LOCK_COUNT   = 16;
    localparam int UNLOCK_COUNT = 4;

    logic       clk, reset_n, data_valid, clear_counts;
    logic [0:0] din_a;
    logic [3:0] din_b;
    logic [7:0] din_c;
    logic       lk_a, lk_b, lk_c, ev_a, ev_b, ev_c;
    logic [0:0] be_a;
    logic [3:0] be_b, cnt_c;
    logic [7:0] be_c;
    logic [15:0] cnt_a, cnt_b;

    prbs_checker #(.BITS_PER_CLOCK(1), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT),
                   .ERR_CNT_WIDTH(16)) u_n1 (
        .clk(clk), .reset_n(reset_n), .data_in(din_a), .data_valid(data_valid),
        .clear_counts(clear_counts), .locked(lk_a), .bit_error(be_a),
        .error_valid(ev_a), .error_count(cnt_a));

    prbs_checker #(.BITS_PER_CLOCK(4), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT),
                   .ERR_CNT_WIDTH(16)) u_n4 (
        .clk(clk), .reset_n(reset_n), .data_in(din_b), .data_valid(data_valid),
        .clear_counts(clear_counts), .locked(lk_b), .bit_error(be_b),
        .error_valid(ev_b), .error_count(cnt_b));

    prbs_checker #(.BITS_PER_CLOCK(8), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT),
                   .ERR_CNT_WIDTH(4)) u_n8 (
        .clk(clk), .reset_n(reset_n), .data_in(din_c), .data_valid(data_valid),
        .clear_counts(clear_counts), .locked(lk_c), .bit_error(be_c),
        .error_valid(ev_c), .error_count(cnt_c));

    logic        a_lock [3];
    logic        a_ev   [3];
    logic [7:0]  a_be   [3];
    logic [15:0] a_cnt  [3];

    assign a_lock[0] = lk_a;
    assign a_lock[1] = lk_b;
    assign a_lock[2] = lk_c;
    assign a_ev[0]   = ev_a;
    assign a_ev[1]   = ev_b;
    assign a_ev[2]   = ev_c;
    assign a_be[0]   = {7'b0, be_a};
    assign a_be[1]   = {4'b0, be_b};
    assign a_be[2]   = be_c;
    assign a_cnt[0]  = cnt_a;
    assign a_cnt[1]  = cnt_b;
    assign a_cnt[2]  = {12'b0, cnt_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nb(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    function automatic int cmax(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic logic [7:0] nmask(input int k);
        return 8'((9'd1 << nb(k)) - 9'd1);
    endfunction

    // Stream source and per-instance corruption: mode 0 clean, 1 inverted, 2 all-zero.
    logic [7:0] gen_h [3];
    int         mode  [3];
    logic [7:0] flip  [3];

    // Reference model state and expected outputs.
    logic [7:0] m_h    [3];
    bit         m_lock [3];
    int         m_fill [3], m_run [3], m_bad [3];
    logic [7:0] e_be   [3];
    logic       e_ev   [3];
    int         e_cnt  [3];

    function automatic logic rec(input logic [7:0] h);
        return h[3] ^ h[4] ^ h[5] ^ h[7];
    endfunction

    task automatic next_word(input int k, output logic [7:0] w);
        logic b;
        w = '0;
        for (int i = nb(k) - 1; i >= 0; i--) begin
            b        = rec(gen_h[k]);
            w[i]     = b;
            gen_h[k] = {gen_h[k][6:0], b};
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_h[k] = '0; m_lock[k] = 0; m_fill[k] = 0; m_run[k] = 0; m_bad[k] = 0;
            e_be[k] = '0; e_ev[k] = 1'b0; e_cnt[k] = 0;
        end
    endtask

    task automatic model_word(input int k, input logic v, input logic clr, input logic [7:0] w);
        int         n;
        logic [7:0] h, mism;
        logic       p, pre_nz;
        n = nb(k);
        h = m_h[k];
        mism = '0;
        e_ev[k] = 1'b0;
        if (v) begin
            if (!m_lock[k]) begin
                if (m_fill[k] < (8 + n - 1) / n) begin
                    for (int i = n - 1; i >= 0; i--) h = {h[6:0], w[i]};
                    m_fill[k]++;
                end else begin
                    pre_nz = (h != 0);
                    for (int i = n - 1; i >= 0; i--) begin
                        p = rec(h); mism[i] = p ^ w[i]; h = {h[6:0], w[i]};
                    end
                    m_run[k] = (mism == 0 && pre_nz) ? m_run[k] + 1 : 0;
                    if (m_run[k] == LOCK_COUNT) begin
                        m_lock[k] = 1; m_run[k] = 0; m_bad[k] = 0;
                    end
                end
            end else begin
                for (int i = n - 1; i >= 0; i--) begin
                    p = rec(h); mism[i] = p ^ w[i]; h = {h[6:0], p};
                end
                e_be[k] = mism;
                e_ev[k] = 1'b1;
                if (!clr) begin
                    e_cnt[k] = e_cnt[k] + $countones(mism);
                    if (e_cnt[k] > cmax(k)) e_cnt[k] = cmax(k);
                end
                m_bad[k] = (mism != 0) ? m_bad[k] + 1 : 0;
                if (m_bad[k] == UNLOCK_COUNT) begin
                    m_lock[k] = 0; m_fill[k] = 0; m_run[k] = 0; m_bad[k] = 0;
                end
            end
            m_h[k] = h;
        end
        if (clr) e_cnt[k] = 0;
    endtask

    // One clock: drive all instances, advance the model, compare #1 after the edge.
    task automatic step(input logic v, input logic clr);
        logic [7:0] w [3];
        for (int k = 0; k < 3; k++) begin
            if (v) begin
                next_word(k, w[k]);
                if (mode[k] == 1)      w[k] = ~w[k];
                else if (mode[k] == 2) w[k] = '0;
                w[k] = (w[k] ^ flip[k]) & nmask(k);
            end else begin
                w[k] = 8'($urandom) & nmask(k);
            end
            model_word(k, v, clr, w[k]);
        end
        din_a = w[0][0:0];
        din_b = w[1][3:0];
        din_c = w[2];
        data_valid   = v;
        clear_counts = clr;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("locked[%0d]", k), 32'(a_lock[k]), 32'(m_lock[k]));
            check($sformatf("error_valid[%0d]", k), 32'(a_ev[k]), 32'(e_ev[k]));
            check($sformatf("bit_error[%0d]", k), 32'(a_be[k]), 32'(e_be[k]));
            check($sformatf("error_count[%0d]", k), 32'(a_cnt[k]), 32'(e_cnt[k]));
        end
    endtask

    // Counts valid words until each instance shows locked; 0 means the budget ran out.
    task automatic measure_lock(input bit toggle, input string tag);
        int  vwords;
        int  at [3];
        logic v;
        vwords = 0;
        at = '{0, 0, 0};
        for (int c = 0; c < 200 && !(a_lock[0] && a_lock[1] && a_lock[2]); c++) begin
            v = toggle ? ((c % 2) == 0) : 1'b1;
            step(v, 1'b0);
            if (v) vwords++;
            for (int k = 0; k < 3; k++) if (a_lock[k] && at[k] == 0) at[k] = vwords;
        end
        check({tag, "_n1"}, at[0], 24);
        check({tag, "_n4"}, at[1], 18);
        check({tag, "_n8"}, at[2], 17);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_locked[%0d]", tag, k), 32'(a_lock[k]), 0);
            check($sformatf("%s_ev[%0d]", tag, k), 32'(a_ev[k]), 0);
            check($sformatf("%s_be[%0d]", tag, k), 32'(a_be[k]), 0);
            check($sformatf("%s_cnt[%0d]", tag, k), 32'(a_cnt[k]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_lock;
        reset_n = 1'b0; data_valid = 1'b0; clear_counts = 1'b0;
        din_a = '0; din_b = '0; din_c = '0;
        for (int k = 0; k < 3; k++) begin
            gen_h[k] = 8'h01; mode[k] = 0; flip[k] = '0;
        end
        model_reset();
        #23;
        check_outputs_zero("reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Lock with valid gaps, then a long clean run.
        measure_lock(1'b1, "lock_gaps");
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0);
        check("clean_cnt_n1", 32'(a_cnt[0]), 0);

        // Single error, then three consecutive errored words on the N=1 stream.
        step(1'b0, 1'b1);
        flip[0] = 8'h01; step(1'b1, 1'b0); flip[0] = '0;
        check("single_be", 32'(a_be[0]), 1);
        check("single_ev", 32'(a_ev[0]), 1);
        check("single_cnt", 32'(a_cnt[0]), 1);
        step(1'b1, 1'b0);
        flip[0] = 8'h01;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        flip[0] = '0;
        step(1'b1, 1'b0);
        check("three_cnt", 32'(a_cnt[0]), 4);
        check("three_locked", 32'(a_lock[0]), 1);

        // Clear in the same cycle as an errored word.
        for (int k = 0; k < 3; k++) flip[k] = 8'h01;
        step(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) flip[k] = '0;
        for (int k = 0; k < 3; k++) check($sformatf("clear_wins[%0d]", k), 32'(a_cnt[k]), 0);

        // Random valid, sparse single-bit errors and occasional clears.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++)
                flip[k] = ($urandom_range(0, 15) == 0) ? 8'(8'h01 << $urandom_range(0, nb(k) - 1)) : 8'h00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        for (int k = 0; k < 3; k++) flip[k] = '0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

        // Twenty isolated single-bit errors: the 4-bit counter saturates at 15.
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 3; k++) flip[k] = 8'(8'h01 << $urandom_range(0, nb(k) - 1));
            step(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) flip[k] = '0;
            step(1'b1, 1'b0);
        end
        check("sat_n1", 32'(a_cnt[0]), 20);
        check("sat_n4", 32'(a_cnt[1]), 20);
        check("sat_n8", 32'(a_cnt[2]), 15);

        // Inverted stream: unlock after four errored words, never relock.
        step(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) mode[k] = 1;
        seen_lock = 0;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'b0);
            if (i == 0) check("inv_be_n4", 32'(a_be[1]), 32'h0F);
            if (i == 2) check("inv_still_locked_n4", 32'(a_lock[1]), 1);
            if (i == 3) check("inv_unlocked_n4", 32'(a_lock[1]), 0);
            if (i > 3 && (a_lock[0] || a_lock[1] || a_lock[2])) seen_lock = 1;
        end
        check("inv_no_relock", 32'(seen_lock), 0);
        check("inv_cnt_n1", 32'(a_cnt[0]), 4);
        check("inv_cnt_n4", 32'(a_cnt[1]), 16);
        check("inv_cnt_n8", 32'(a_cnt[2]), 15);

        // All-zero stream never locks.
        for (int k = 0; k < 3; k++) mode[k] = 2;
        seen_lock = 0;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 1'b0);
            if (a_lock[0] || a_lock[1] || a_lock[2]) seen_lock = 1;
        end
        check("zero_no_lock", 32'(seen_lock), 0);

        // Relock on a clean stream, then reset asynchronously mid-LOCKED.
        for (int k = 0; k < 3; k++) mode[k] = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) check($sformatf("pre_reset_locked[%0d]", k), 32'(a_lock[k]), 1);
        data_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_reset();
        for (int k = 0; k < 3; k++) gen_h[k] = 8'h01;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        measure_lock(1'b0, "relock");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
